// File: rtl/tbox_lookup_if.sv
// Valid/ready bundle between the round state register and the T-table lookup unit.
interface tbox_lookup_if #(
  parameter int LANES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*LANES-1:0]    in_data;
  logic [1:0]            in_tsel;
  logic                  in_final;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_tsel, in_final, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_tsel, in_final, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tbox_lookup_pipe.sv
// Pipelined AES Te0..Te3 / final-round S-box lookup for LANES bytes per transaction,
// throttled by valid/ready with a combinational stall chain.
module tbox_lookup_pipe #(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic           clk,
  input  logic           rst,
  tbox_lookup_if.slave   bus
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x))*8 +: 8];
  endfunction

  // Te_k is Te0 rotated right by 8k; final mode keeps only the S2 byte position, loaded with S.
  function automatic logic [31:0] tword(input logic [7:0] s, input logic [1:0] k, input logic fin);
    logic [7:0]  s2;
    logic [7:0]  s3;
    logic [31:0] w;
    s2 = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    s3 = s2 ^ s;
    w  = '0;
    if (fin) begin
      case (k)
        2'd0:    w = {s, 24'h000000};
        2'd1:    w = {8'h00, s, 16'h0000};
        2'd2:    w = {16'h0000, s, 8'h00};
        default: w = {24'h000000, s};
      endcase
    end else begin
      case (k)
        2'd0:    w = {s2, s, s, s3};
        2'd1:    w = {s3, s2, s, s};
        2'd2:    w = {s, s3, s2, s};
        default: w = {s, s, s3, s2};
      endcase
    end
    return w;
  endfunction

  logic [8*LANES-1:0] sb_comb;

  always_comb begin
    sb_comb = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sb_comb[8*i +: 8] = sbox(bus.in_data[8*i +: 8]);
    end
  end

  if (PIPE == 1) begin : g_one
    logic                v;
    logic                ld;
    logic [32*LANES-1:0] d;
    logic [32*LANES-1:0] w;

    assign ld = ~v | bus.out_ready;

    always_comb begin
      w = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        w[32*i +: 32] = tword(sb_comb[8*i +: 8], bus.in_tsel, bus.in_final);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (ld) begin
        v <= bus.in_valid;
        if (bus.in_valid) d <= w;
      end
    end

    assign bus.in_ready  = ld;
    assign bus.out_valid = v;
    assign bus.out_data  = d;
  end else begin : g_two
    logic                s1_valid;
    logic [8*LANES-1:0]  s1_sbox;
    logic [1:0]          s1_tsel;
    logic                s1_final;
    logic                s2_valid;
    logic [32*LANES-1:0] s2_data;
    logic                s1_load;
    logic                s2_load;
    logic [32*LANES-1:0] w;

    // Stage 1 may refill whenever stage 2 is taking its contents, giving full throughput.
    assign s2_load = ~s2_valid | bus.out_ready;
    assign s1_load = ~s1_valid | s2_load;

    always_comb begin
      w = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        w[32*i +: 32] = tword(s1_sbox[8*i +: 8], s1_tsel, s1_final);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_sbox  <= '0;
        s1_tsel  <= '0;
        s1_final <= 1'b0;
      end else if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sbox  <= sb_comb;
          s1_tsel  <= bus.in_tsel;
          s1_final <= bus.in_final;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= w;
      end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
  end

endmodule
